// File: rtl/pw_tile_writer.sv
// Pointwise tile writer: scatters a channel-innermost element stream (row, col, ch)
// into planar CHW tile memory, one registered write per accepted beat.
module pw_tile_writer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_tile_h,
   input  logic [DIM_W-1:0]  cfg_tile_w,
   input  logic [DIM_W-1:0]  cfg_channels,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_first_ch,
   input  logic              in_last_ch,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Handshakes: a beat transfers on the rising edge where in_valid && in_ready;
   // a write transfers where wr_en && wr_ready, and wr_en/wr_addr/wr_data hold until then.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [DIM_W-1:0]    r_h;
   logic [DIM_W-1:0]    r_w;
   logic [DIM_W-1:0]    r_c;
   logic [ADDR_W-1:0]   r_plane;
   logic [ADDR_W-1:0]   r_base;
   logic [DIM_W-1:0]    r_ch;
   logic [DIM_W-1:0]    r_col;
   logic [DIM_W-1:0]    r_row;
   logic [ADDR_W-1:0]   r_ch_off;
   logic [ADDR_W-1:0]   r_pix_off;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic                w_cfg_zero;
   logic                w_wr_fire;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_ch_last;
   logic                w_col_last;
   logic                w_row_last;
   logic                w_tile_last;
   logic                w_flag_bad;
   logic [ADDR_W-1:0]   w_addr;
   logic [2*DIM_W-1:0]  w_plane_full;

   assign w_cfg_zero   = (cfg_tile_h == '0) || (cfg_tile_w == '0) || (cfg_channels == '0);
   assign w_plane_full = (2*DIM_W)'(cfg_tile_h) * (2*DIM_W)'(cfg_tile_w);
   assign w_wr_fire    = r_wr_en && wr_ready;
   assign w_in_ready   = (r_state == S_RUN) && (!r_wr_en || wr_ready);
   assign w_accept     = in_valid && w_in_ready;
   assign w_ch_last    = (r_ch  == r_c - DIM_W'(1));
   assign w_col_last   = (r_col == r_w - DIM_W'(1));
   assign w_row_last   = (r_row == r_h - DIM_W'(1));
   assign w_tile_last  = w_ch_last && w_col_last && w_row_last;
   assign w_flag_bad   = (in_first_ch != (r_ch == '0)) || (in_last_ch != w_ch_last);

   // ch_off tracks ch*plane and pix_off tracks row*W+col, so no multiplier sits in the beat path.
   assign w_addr = r_base + r_ch_off + r_pix_off;

   always_comb begin
      w_state_next = r_state;
      if (start) begin
         w_state_next = w_cfg_zero ? S_IDLE : S_RUN;
      end else begin
         case (r_state)
            S_RUN:   if (w_accept && w_tile_last) w_state_next = S_DRAIN;
            S_DRAIN: if (w_wr_fire) w_state_next = S_IDLE;
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h       <= '0;
         r_w       <= '0;
         r_c       <= '0;
         r_plane   <= '0;
         r_base    <= '0;
         r_ch      <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_ch_off  <= '0;
         r_pix_off <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else if (start) begin
         // Start wins over everything else this cycle: any pending write is dropped.
         r_h       <= cfg_tile_h;
         r_w       <= cfg_tile_w;
         r_c       <= cfg_channels;
         r_plane   <= ADDR_W'(w_plane_full);
         r_base    <= cfg_base_addr;
         r_ch      <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_ch_off  <= '0;
         r_pix_off <= '0;
         r_wr_en   <= 1'b0;
         r_busy    <= !w_cfg_zero;
         r_done    <= w_cfg_zero;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_wr_fire) begin
            r_wr_en <= 1'b0;
         end
         if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_data <= in_data;
            if (w_flag_bad) begin
               r_err <= 1'b1;
            end
            if (w_ch_last) begin
               r_ch      <= '0;
               r_ch_off  <= '0;
               r_pix_off <= r_pix_off + ADDR_W'(1);
               if (w_col_last) begin
                  r_col <= '0;
                  r_row <= r_row + DIM_W'(1);
               end else begin
                  r_col <= r_col + DIM_W'(1);
               end
            end else begin
               r_ch     <= r_ch + DIM_W'(1);
               r_ch_off <= r_ch_off + r_plane;
            end
         end
         if ((r_state == S_DRAIN) && w_wr_fire) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_pw_tile_writer.sv
// Bench for pw_tile_writer: CHW address model with an expected-write queue,
// a per-cycle compare process, and directed tile scenarios.
module tb_pw_tile_writer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] cfg_tile_h;
   logic [15:0] cfg_tile_w;
   logic [15:0] cfg_channels;
   logic [31:0] cfg_base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_first_ch;
   logic        in_last_ch;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  dbg_state;

   logic [39:0] exp_q[$];
   int          n_tests;
   int          n_fail;
   int          cyc;
   int          last_hs_cyc;
   int          ready_mode;
   logic        prev_stall;
   logic [31:0] prev_addr;
   logic [7:0]  prev_data;

   pw_tile_writer #(.DATA_W(8), .ADDR_W(32), .DIM_W(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_tile_h(cfg_tile_h), .cfg_tile_w(cfg_tile_w), .cfg_channels(cfg_channels),
      .cfg_base_addr(cfg_base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first_ch(in_first_ch), .in_last_ch(in_last_ch),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // 0: always ready, 1: toggle each cycle, 2: held low
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = ~wr_ready;
         default: wr_ready = 1'b0;
      endcase
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] beat_data(input int k, input logic [31:0] base);
      return 8'(k * 37) ^ base[7:0] ^ 8'h5A;
   endfunction

   // Model: planar CHW placement of every element, in stream order.
   task automatic push_tile(input int h, input int w, input int c, input logic [31:0] base);
      for (int row = 0; row < h; row++)
         for (int col = 0; col < w; col++)
            for (int ch = 0; ch < c; ch++) begin
               logic [31:0] a;
               int          k;
               k = (row * w + col) * c + ch;
               a = base + 32'(ch * h * w + row * w + col);
               exp_q.push_back({a, beat_data(k, base)});
            end
   endtask

   // scoreboard / compare process
   always @(negedge clk) begin
      logic [39:0] e;
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_wr_en", wr_en, 1'b1);
            chk("stall_addr", wr_addr, prev_addr);
            chk("stall_data", wr_data, prev_data);
         end
         if (wr_en && !wr_ready) chk("in_ready_blocked", in_ready, 1'b0);
         if (!busy) chk("in_ready_idle", in_ready, 1'b0);
         if (wr_en && wr_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_write actual addr=%0h data=%0h expected none", wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e[39:8]);
               chk("wr_data", wr_data, e[7:0]);
               last_hs_cyc <= cyc;
            end
         end
      end
      prev_stall <= !rst && !start && wr_en && !wr_ready;
      prev_addr  <= wr_addr;
      prev_data  <= wr_data;
   end

   // driver tasks (entered and left 1 time unit after a rising edge)
   task automatic do_start(input int h, input int w, input int c, input logic [31:0] base);
      cfg_tile_h    = 16'(h);
      cfg_tile_w    = 16'(w);
      cfg_channels  = 16'(c);
      cfg_base_addr = base;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drive_tile(input int h, input int w, input int c, input logic [31:0] base,
                             input int err_beat, input int limit, input bit hold);
      int n;
      int ch;
      bit acc;
      n = h * w * c;
      if (limit >= 0 && limit < n) n = limit;
      for (int k = 0; k < n; k++) begin
         ch          = k % c;
         in_data     = beat_data(k, base);
         in_first_ch = (ch == 0);
         in_last_ch  = (ch == c - 1) || (k == err_beat);
         in_valid    = 1'b1;
         acc = 1'b0;
         for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
               acc = 1'b1;
               break;
            end
         end
         @(posedge clk);
         #1;
         if (!acc) begin
            chk("accept_timeout", 64'(acc), 64'd1);
            in_valid = 1'b0;
            return;
         end
         chk("busy_run", busy, 1'b1);
         if (err_beat >= 0 && k >= err_beat) chk("err_set", err, 1'b1);
         else chk("err_clear", err, 1'b0);
      end
      in_valid = hold;
   endtask

   task automatic wait_done(input logic exp_err);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      chk("done_seen", 64'(got), 64'd1);
      if (got) begin
         chk("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
         chk("busy_at_done", busy, 1'b0);
         chk("queue_empty", 64'(exp_q.size()), 64'd0);
         chk("err_at_done", err, exp_err);
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("done_one_cycle", done, 1'b0);
      chk("err_after_done", err, exp_err);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; last_hs_cyc = 0; ready_mode = 0;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      in_first_ch = 1'b0; in_last_ch = 1'b0; wr_ready = 1'b1;
      cfg_tile_h = '0; cfg_tile_w = '0; cfg_channels = '0; cfg_base_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_wr_data", wr_data, 8'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: 2x2x3 at 0x100, continuous, extra valid held after the last beat
      ready_mode = 0;
      push_tile(2, 2, 3, 32'h100);
      chk("model_n", 64'(exp_q.size()), 64'd12);
      chk("model_a0", exp_q[0][39:8], 32'h100);
      chk("model_a1", exp_q[1][39:8], 32'h104);
      chk("model_a2", exp_q[2][39:8], 32'h108);
      chk("model_a3", exp_q[3][39:8], 32'h101);
      chk("model_a11", exp_q[11][39:8], 32'h10B);
      do_start(2, 2, 3, 32'h100);
      drive_tile(2, 2, 3, 32'h100, -1, -1, 1'b1);
      wait_done(1'b0);

      // 2: same tile, write side stalls every other cycle
      ready_mode = 1;
      push_tile(2, 2, 3, 32'h100);
      do_start(2, 2, 3, 32'h100);
      drive_tile(2, 2, 3, 32'h100, -1, -1, 1'b0);
      wait_done(1'b0);

      // 3: address wrap past 2^32
      ready_mode = 0;
      push_tile(1, 3, 1, 32'hFFFF_FFFE);
      chk("model_wrap1", exp_q[1][39:8], 32'hFFFF_FFFF);
      chk("model_wrap2", exp_q[2][39:8], 32'h0);
      do_start(1, 3, 1, 32'hFFFF_FFFE);
      drive_tile(1, 3, 1, 32'hFFFF_FFFE, -1, -1, 1'b0);
      wait_done(1'b0);

      // 4: bad in_last_ch on beat index 1; all four writes still issue
      push_tile(1, 1, 4, 32'h40);
      do_start(1, 1, 4, 32'h40);
      drive_tile(1, 1, 4, 32'h40, 1, -1, 1'b0);
      wait_done(1'b1);

      // 5: zero channel count; also clears err from the previous tile
      do_start(2, 2, 0, 32'h500);
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      chk("zero_wr_en", wr_en, 1'b0);
      chk("zero_err_cleared", err, 1'b0);
      @(posedge clk);
      #1;
      chk("zero_done_pulse", done, 1'b0);
      chk("zero_wr_en2", wr_en, 1'b0);

      // 6a: restart while a write is held
      ready_mode = 2;
      push_tile(2, 2, 3, 32'h100);
      do_start(2, 2, 3, 32'h100);
      drive_tile(2, 2, 3, 32'h100, 0, 1, 1'b0);
      @(negedge clk);
      #1;
      chk("held_wr_en", wr_en, 1'b1);
      chk("held_addr", wr_addr, 32'h100);
      chk("held_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      exp_q.delete();
      push_tile(1, 2, 2, 32'h200);
      do_start(1, 2, 2, 32'h200);
      chk("abort_wr_en", wr_en, 1'b0);
      chk("abort_busy", busy, 1'b1);
      chk("abort_err", err, 1'b0);
      ready_mode = 0;
      drive_tile(1, 2, 2, 32'h200, -1, -1, 1'b0);
      wait_done(1'b0);

      // 6b: reset mid-tile
      ready_mode = 2;
      push_tile(2, 2, 2, 32'h300);
      do_start(2, 2, 2, 32'h300);
      drive_tile(2, 2, 2, 32'h300, 0, 1, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mrst_in_ready", in_ready, 1'b0);
      chk("mrst_wr_en", wr_en, 1'b0);
      chk("mrst_wr_addr", wr_addr, 32'h0);
      chk("mrst_wr_data", wr_data, 8'h0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_done", done, 1'b0);
      chk("mrst_err", err, 1'b0);
      chk("mrst_state", dbg_state, 2'd0);
      exp_q.delete();
      ready_mode = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mrst_no_done", done, 1'b0);
         chk("mrst_no_write", wr_en, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
